seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits scanned.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is captured.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port digit_sel, input, NUM_DIGITS: one-hot active-high digit strobe; bit i selects digit i.
REQ-006 SHALL have port segments, input, 7: active-high segment lines; [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
REQ-007 SHALL have port value, output, 4*NUM_DIGITS: decoded frame; nibble i from digit i.
REQ-008 SHALL have port digit_err, output, NUM_DIGITS: bit i set when digit i's pattern matched no glyph.
REQ-009 SHALL have port frame_valid, output, 1: value and digit_err hold a complete, unconsumed frame.
REQ-010 SHALL have port frame_ready, input, 1: consumer accepts the frame.
REQ-011 SHALL have port overflow, output, 1: sticky flag, a frame was dropped while one was pending.

Function
REQ-012 SHALL decode exactly these patterns: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. Any other pattern SHALL decode to nibble 0 with the error bit set.
REQ-013 SHALL keep a stability counter that loads 1 when {digit_sel, segments} differs from the previous cycle's sample, and otherwise increments, saturating at STABLE_CYCLES.
REQ-014 SHALL capture digit i in the cycle the counter first reaches STABLE_CYCLES while digit_sel is one-hot with bit i set. Exactly one capture SHALL occur per stable period.
REQ-015 SHALL never capture when digit_sel is all-zero or has more than one bit set. Such samples still reset or advance the counter per REQ-013.
REQ-016 SHALL store each capture in an internal nibble/error shadow and set bit i of an internal captured mask. A recapture of the same digit before frame completion SHALL overwrite that shadow entry.
REQ-017 SHALL complete a frame on the cycle the captured mask becomes all-ones. On the next cycle it SHALL copy the shadow to value and digit_err, assert frame_valid, and clear the mask.
REQ-018 SHALL use FSM states SCAN and PEND. SCAN goes to PEND on frame completion. PEND goes to SCAN on the cycle frame_valid and frame_ready are both high.
REQ-019 SHALL hold frame_valid, value and digit_err stable while in PEND until the handshake occurs. Capture into the shadow SHALL continue during PEND.
REQ-020 SHALL, when a frame completes in PEND without a handshake in that same cycle, discard the new frame, set overflow, and clear the mask.
REQ-021 SHALL, when a frame completes in the same cycle as a handshake, load the new frame and keep frame_valid high with no dropped frame.
REQ-022 SHALL clear overflow only by reset.
REQ-023 SHALL ignore frame_ready while frame_valid is low.

Reset
REQ-024 SHALL on reset set value=0, digit_err=0, frame_valid=0, overflow=0, state=SCAN, mask=0, counter=0, and clear the shadow and the previous-sample register.
REQ-025 SHALL let reset mid-scan or mid-PEND discard all partial and pending frames. The first capture after reset SHALL need a full STABLE_CYCLES period.

Structure
REQ-026 SHALL place the 16 glyph constants and the state type in a shared package, seg_pkg, so they match the existing hex-to-segment encoder.
REQ-027 SHALL implement the glyph lookup as a combinational sub-module seg2hex, with ports segments[6:0], hex[3:0] and invalid.

Verification
REQ-028 SHALL cover a scan of digits 0..3 with patterns 79,5B,70,4F, each held 6 cycles -> frame_valid rises with value=16'hE753 and digit_err=0.
REQ-029 SHALL cover digit 2 showing 0x00 while the other digits are valid -> digit_err=4'b0100 and nibble 2 reads 0.
REQ-030 SHALL cover a 3-cycle glitch pattern between held digits with STABLE_CYCLES=4 -> no capture from the glitch, and the frame value is unchanged.
REQ-031 SHALL cover frame_ready held low across two full scans -> the first frame stays on value and overflow=1.
REQ-032 SHALL cover frame_ready pulsed in the cycle a new frame completes -> frame_valid stays 1, value updates, and overflow=0.
REQ-033 SHALL cover digit_sel=4'b0011 held 10 cycles -> no capture; and reset asserted mid-scan -> all outputs are 0 the next cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment glyph table and scan FSM state type.
// The glyph order matches the hex-to-segment encoder: index = nibble value.
package seg_pkg;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Segment order {a,b,c,d,e,f,g}, active high.
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Frame output bus of the scan decoder: decoded frame, per-digit errors,
// valid/ready handshake and the sticky overflow flag.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overflow;

  modport master (
    output value, digit_err, frame_valid, overflow,
    input  frame_ready
  );

  modport slave (
    input  value, digit_err, frame_valid, overflow,
    output frame_ready
  );
endinterface

// File: rtl/seg2hex.sv
// Combinational seven-segment to hex lookup; unknown patterns give 0 + invalid.
module seg2hex
  import seg_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] hex,
  output logic       invalid
);

  always_comb begin
    hex     = 4'h0;
    invalid = 1'b1;
    for (int g = 0; g < 16; g++) begin
      if (segments == GLYPH[g]) begin
        hex     = 4'(g);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment display, debounces each digit strobe and
// assembles decoded digits into frames handed off over a valid/ready handshake.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [6:0]              segments,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overflow
);

  localparam int          SW    = NUM_DIGITS + 7;
  localparam logic [7:0]  CSTAB = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_t                       r_state, w_state_nxt;
  logic [SW-1:0]                r_prev;
  logic [SW-1:0]                w_sample;
  logic [7:0]                   r_cnt, w_cnt_nxt;
  logic [NUM_DIGITS-1:0][3:0]   r_sh_val;
  logic [NUM_DIGITS-1:0]        r_sh_err;
  logic [NUM_DIGITS-1:0]        r_mask;
  logic [NUM_DIGITS-1:0][3:0]   r_value;
  logic [NUM_DIGITS-1:0]        r_err;
  logic                         r_ovf;
  logic [3:0]                   w_hex;
  logic                         w_inv;
  logic                         w_onehot;
  logic                         w_cap;
  logic                         w_full;
  logic                         w_hs;
  logic                         w_load;
  logic                         w_drop;

  seg2hex u_seg2hex (
    .segments (segments),
    .hex      (w_hex),
    .invalid  (w_inv)
  );

  assign w_sample = {digit_sel, segments};
  assign w_onehot = (digit_sel != '0) && ((digit_sel & (digit_sel - ONE)) == '0);

  always_comb begin
    if (w_sample != r_prev)  w_cnt_nxt = 8'd1;
    else if (r_cnt < CSTAB)  w_cnt_nxt = r_cnt + 8'd1;
    else                     w_cnt_nxt = r_cnt;
  end

  // Capture only on the transition into saturation so each stable period yields one capture.
  assign w_cap  = w_onehot && (w_cnt_nxt == CSTAB) && (r_cnt != CSTAB);
  assign w_full = &r_mask;
  assign w_hs   = (r_state == ST_PEND) && frame_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_full) begin
          // A handshake in the completion cycle frees the slot for the new frame.
          if (w_hs) w_load = 1'b1;
          else      w_drop = 1'b1;
        end else if (w_hs) begin
          w_state_nxt = ST_SCAN;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SCAN;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_value <= '0;
      r_err   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_sample;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_value <= r_sh_val;
        r_err   <= r_sh_err;
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_full)     r_mask <= '0;
      else if (w_cap) r_mask <= r_mask | digit_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_val <= '0;
      r_sh_err <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel[i]) begin
          r_sh_val[i] <= w_hex;
          r_sh_err[i] <= w_inv;
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_err   = r_err;
  assign frame_valid = (r_state == ST_PEND);
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: a behavioural model predicts delivered frames into a queue;
// a monitor pops and compares whenever the decoder presents a new frame.
module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 4;

  typedef struct packed {
    logic [4*ND-1:0] val;
    logic [ND-1:0]   err;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [ND-1:0] digit_sel = '0;
  logic [6:0]    segments = '0;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_sel   (digit_sel),
    .segments    (segments),
    .value       (bus.value),
    .digit_err   (bus.digit_err),
    .frame_valid (bus.frame_valid),
    .frame_ready (bus.frame_ready),
    .overflow    (bus.overflow)
  );

  logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int     errors = 0;
  int     checks = 0;
  frame_t exp_q[$];

  // Reference model state: last sample, run length, captured digits, shadow.
  int            m_cnt = 0;
  logic [ND+6:0] m_prev = '0;
  logic [ND-1:0] m_mask = '0;
  logic [3:0]    m_sh_val [ND];
  logic          m_sh_err [ND];
  bit            m_pend = 0;
  bit            m_ovf = 0;

  logic   mon_pfv = 1'b0;
  frame_t mon_cur = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic decode(input logic [6:0] s, output logic [3:0] h, output logic e);
    h = 4'h0;
    e = 1'b1;
    for (int g = 0; g < 16; g++)
      if (GLY[g] == s) begin
        h = 4'(g);
        e = 1'b0;
      end
  endtask

  task automatic model_step(input logic rst, input logic [ND-1:0] ds, input logic [6:0] sg,
                            input logic rdy);
    logic [ND+6:0] smp;
    int            nc;
    frame_t        f;
    logic [3:0]    h;
    logic          e;
    if (rst) begin
      m_cnt = 0; m_prev = '0; m_mask = '0; m_pend = 0; m_ovf = 0;
      for (int i = 0; i < ND; i++) begin
        m_sh_val[i] = '0;
        m_sh_err[i] = 1'b0;
      end
      return;
    end
    if (m_mask == '1) begin
      for (int i = 0; i < ND; i++) begin
        f.val[4*i +: 4] = m_sh_val[i];
        f.err[i]        = m_sh_err[i];
      end
      m_mask = '0;
      if (!m_pend || rdy) begin
        exp_q.push_back(f);
        m_pend = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_pend && rdy) begin
      m_pend = 0;
    end
    smp = {ds, sg};
    nc  = (smp != m_prev) ? 1 : ((m_cnt < SC) ? m_cnt + 1 : SC);
    if (nc == SC && m_cnt != SC && $countones(ds) == 1) begin
      decode(sg, h, e);
      for (int i = 0; i < ND; i++)
        if (ds[i]) begin
          m_sh_val[i] = h;
          m_sh_err[i] = e;
          m_mask[i]   = 1'b1;
        end
    end
    m_prev = smp;
    m_cnt  = nc;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready only on a frame-completion cycle.
  task automatic cyc(input logic rst, input logic [ND-1:0] ds, input logic [6:0] sg,
                     input int rmode);
    logic rdy;
    @(negedge clk);
    rdy = (rmode == 2) ? (m_mask == '1) : (rmode == 1);
    reset           = rst;
    digit_sel       = ds;
    segments        = sg;
    bus.frame_ready = rdy;
    model_step(rst, ds, sg, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [3:0][6:0] p, input int rmode, input bit glitch);
    for (int d = 0; d < ND; d++) begin
      repeat (6) cyc(1'b0, ND'(1 << d), p[d], rmode);
      if (glitch && d < ND - 1) repeat (3) cyc(1'b0, 4'b0100, 7'h7F, rmode);
    end
  endtask

  task automatic idle(input int n, input int rmode);
    repeat (n) cyc(1'b0, '0, 7'h00, rmode);
  endtask

  // Monitor: a new frame is visible when valid rises or reloads after a handshake.
  initial begin
    logic hs, nf;
    forever begin
      @(posedge clk);
      #1;
      hs = mon_pfv && bus.frame_ready;
      nf = bus.frame_valid && (!mon_pfv || hs);
      if (nf) begin
        if (exp_q.size() == 0) begin
          chk("frame_expected_in_queue", exp_q.size(), 1);
        end else begin
          mon_cur = exp_q.pop_front();
          chk("frame_value", bus.value, mon_cur.val);
          chk("frame_err", bus.digit_err, mon_cur.err);
        end
      end else begin
        chk("frame_missing", exp_q.size(), 0);
        if (bus.frame_valid)
          chk("frame_hold", {bus.value, bus.digit_err}, {mon_cur.val, mon_cur.err});
      end
      chk("overflow", bus.overflow, m_ovf);
      mon_pfv = bus.frame_valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [ND-1:0] ds;
    logic [6:0]    sg;
    bus.frame_ready = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_sh_val[i] = '0;
      m_sh_err[i] = 1'b0;
    end

    cyc(1'b1, '0, 7'h00, 0);
    cyc(1'b1, '0, 7'h00, 0);
    chk("rst_value", bus.value, 0);
    chk("rst_err", bus.digit_err, 0);
    chk("rst_valid", bus.frame_valid, 0);
    chk("rst_ovf", bus.overflow, 0);

    // Basic scan: digits 3,5,7,E.
    scan({7'h4F, 7'h70, 7'h5B, 7'h79}, 0, 0);
    idle(2, 0);
    chk("scan_value", bus.value, 16'hE753);
    chk("scan_err", bus.digit_err, 0);
    chk("scan_valid", bus.frame_valid, 1);

    // Ready pulsed exactly when the next frame completes: reload, no drop.
    scan({7'h7F, 7'h6D, 7'h30, 7'h7E}, 2, 0);
    idle(1, 0);
    chk("hs_cmpl_valid", bus.frame_valid, 1);
    chk("hs_cmpl_value", bus.value, 16'h8210);
    chk("hs_cmpl_ovf", bus.overflow, 0);
    idle(1, 1);
    chk("hs_release", bus.frame_valid, 0);

    // Blank digit 2 is an error and reads 0.
    scan({7'h4F, 7'h00, 7'h5B, 7'h79}, 0, 0);
    idle(2, 0);
    chk("bad_value", bus.value, 16'hE053);
    chk("bad_err", bus.digit_err, 4'b0100);
    idle(1, 1);

    // Three-cycle glitches between digits must not capture.
    scan({7'h4F, 7'h70, 7'h5B, 7'h79}, 0, 1);
    idle(2, 0);
    chk("glitch_value", bus.value, 16'hE753);
    idle(1, 1);

    // Two scans with no consumer: first frame kept, overflow set.
    scan({7'h7F, 7'h6D, 7'h30, 7'h7E}, 0, 0);
    scan({7'h4F, 7'h70, 7'h5B, 7'h79}, 0, 0);
    idle(2, 0);
    chk("ovf_value", bus.value, 16'h8210);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_valid", bus.frame_valid, 1);

    // Reset clears everything, then multi-hot strobes never capture.
    cyc(1'b1, '0, 7'h00, 0);
    chk("rst2_value", bus.value, 0);
    chk("rst2_valid", bus.frame_valid, 0);
    chk("rst2_ovf", bus.overflow, 0);
    repeat (10) cyc(1'b0, 4'b0011, 7'h30, 0);
    repeat (6) cyc(1'b0, 4'b0100, 7'h70, 0);
    repeat (6) cyc(1'b0, 4'b1000, 7'h4F, 0);
    idle(3, 0);
    chk("multihot_valid", bus.frame_valid, 0);
    // Mid-scan reset drops the partial frame.
    cyc(1'b1, 4'b1000, 7'h4F, 0);
    chk("rst3_value", bus.value, 0);
    chk("rst3_err", bus.digit_err, 0);
    chk("rst3_valid", bus.frame_valid, 0);
    repeat (6) cyc(1'b0, 4'b0001, 7'h79, 0);
    repeat (6) cyc(1'b0, 4'b0010, 7'h5B, 0);
    idle(3, 0);
    chk("post_rst_partial", bus.frame_valid, 0);

    // Randomised scanning with random consumer behaviour.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       ds = ND'(1 << $urandom_range(0, ND - 1));
      else if (r == 8) ds = '0;
      else             ds = ND'($urandom_range(3, 15));
      sg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : GLY[$urandom_range(0, 15)];
      repeat ($urandom_range(1, 7)) cyc(1'b0, ds, sg, int'($urandom_range(0, 2)));
    end
    idle(10, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
